// File: rtl/uart_rx_capture.sv
// 8N1 UART receiver with a first-word fall-through receive FIFO.
// Samples mid-bit from a 2-flop synchronised line and keeps sticky framing/overflow flags.
module uart_rx_capture #(
  parameter int CLK_FREQ   = 25000000,
  parameter int BAUD_RATE  = 781250,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            rx_i,
  input  logic                            rx_en_i,
  output logic [7:0]                      data_o,
  output logic                            valid_o,
  input  logic                            ready_i,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] count_o,
  output logic                            frame_err_o,
  output logic                            overflow_o,
  input  logic                            clr_err_i
);

  localparam int DIV  = CLK_FREQ / BAUD_RATE;
  localparam int HALF = DIV / 2;
  localparam int DCW  = $clog2(DIV);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CW   = $clog2(FIFO_DEPTH + 1);

  if (DIV < 4) begin : g_bad_div
    $error("uart_rx_capture: CLK_FREQ/BAUD_RATE must be at least 4");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_rx_capture: FIFO_DEPTH must be a power of two >= 2");
  end

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

  state_t         state;
  logic [1:0]     sync;
  logic [1:0]     fill;
  logic           armed;
  logic           rx_s;
  logic [DCW-1:0] div_cnt;
  logic [2:0]     bit_idx;
  logic [7:0]     shift;
  logic           half_tick;
  logic           bit_tick;
  logic           stop_good;
  logic           stop_bad;

  logic [7:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [CW-1:0]  count;
  logic           full;
  logic           push;
  logic           pop;
  logic           drop;

  assign rx_s      = sync[1];
  assign half_tick = (div_cnt == DCW'(HALF - 1));
  assign bit_tick  = (div_cnt == DCW'(DIV - 1));
  assign stop_good = (state == STOP) && bit_tick && rx_s;
  assign stop_bad  = (state == STOP) && bit_tick && !rx_s;

  // The synchroniser resets to idle-high, so a line that is low when reset
  // releases is not a start bit; armed waits for a genuine high sample first.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync  <= 2'b11;
      fill  <= 2'b00;
      armed <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      sync <= {sync[0], rx_i};
      fill <= {fill[0], 1'b1};
      if (fill[1] && rx_s) armed <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      div_cnt <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      case (state)
        IDLE: begin
          div_cnt <= '0;
          if (rx_en_i && armed && !rx_s) state <= START;
        end
        START: begin
          if (half_tick) begin
            div_cnt <= '0;
            bit_idx <= '0;
            state   <= rx_s ? IDLE : DATA;
          end else begin
            div_cnt <= div_cnt + DCW'(1);
          end
        end
        DATA: begin
          if (bit_tick) begin
            div_cnt        <= '0;
            shift[bit_idx] <= rx_s;
            if (bit_idx == 3'd7) state <= STOP;
            else bit_idx <= bit_idx + 3'd1;
          end else begin
            div_cnt <= div_cnt + DCW'(1);
          end
        end
        STOP: begin
          if (bit_tick) begin
            div_cnt <= '0;
            state   <= rx_s ? IDLE : WAIT_IDLE;
          end else begin
            div_cnt <= div_cnt + DCW'(1);
          end
        end
        WAIT_IDLE: begin
          div_cnt <= '0;
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A pop frees the head slot on the same edge, so a push into a full FIFO is still accepted.
  always_comb begin
    // NOTE: every always_comb output is assigned on all paths so no latch is inferred.
    full = (count == CW'(FIFO_DEPTH));
    pop  = valid_o && ready_i;
    push = stop_good && (!full || pop);
    drop = stop_good && full && !pop;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is not reset; count/pointers define validity and data_o is masked when empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= shift;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_err_o <= 1'b0;
      overflow_o  <= 1'b0;
    end else begin
      if (stop_bad)       frame_err_o <= 1'b1;
      else if (clr_err_i) frame_err_o <= 1'b0;
      if (drop)           overflow_o  <= 1'b1;
      else if (clr_err_i) overflow_o  <= 1'b0;
    end
  end

  assign valid_o = (count != '0);
  assign count_o = count;
  assign data_o  = valid_o ? mem[rd_ptr] : 8'h00;

endmodule

// File: doc/uart_rx_capture.md
Name: uart_rx_capture

Overview:
- Synthesizable 8N1 UART receiver for the FPGA/board side of pulpino_top.
- Consumes the core's uart_tx line and buffers received bytes in a small FIFO for a host-side consumer (console bridge, LED/status logic).
- Replaces the behavioural uart_bus monitor when the design runs without a testbench.
- Defaults match the 25 MHz system clock and 781250 baud link, giving 32 clocks per bit.

Parameters:
CLK_FREQ, 25000000, system clock frequency in Hz
BAUD_RATE, 781250, line rate in bit/s; DIV = CLK_FREQ/BAUD_RATE (integer division), DIV >= 4 required, elaboration error otherwise
FIFO_DEPTH, 16, receive FIFO entries, power of two, >= 2

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset, sampled on rising edge of clk
rx_i  in  1  serial line from pulpino_top uart_tx, asynchronous, idle high
rx_en_i  in  1  receiver enable; 0 holds FSM in IDLE
data_o  out  8  byte at FIFO head
valid_o  out  1  FIFO non-empty
ready_i  in  1  consumer accepts data_o when valid_o && ready_i
count_o  out  $clog2(FIFO_DEPTH+1)  FIFO occupancy
frame_err_o  out  1  sticky: stop bit sampled low
overflow_o  out  1  sticky: byte dropped, FIFO full
clr_err_i  in  1  clears both sticky flags

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - FSM enters IDLE; bit counter and divider counter go to 0.
  - FIFO is emptied: valid_o=0, count_o=0, data_o=0.
  - frame_err_o=0, overflow_o=0.
  - Synchronizer flops are set to 1.
  - Reset asserted mid-frame aborts the frame; no partial byte is pushed.
- Input sync: rx_i passes through a 2-flop synchronizer; the FSM uses only rx_s.
- FSM states IDLE, START, DATA, STOP, WAIT_IDLE. The divider counter reloads on every state entry.
- IDLE: when rx_en_i=1 and rx_s=0, go to START.
- START: after DIV/2 cycles, sample rx_s.
  - rx_s=0: go to DATA with bit index 0.
  - rx_s=1: glitch; return to IDLE with no flag set.
- DATA: every DIV cycles, sample rx_s into shift register bit [idx], LSB first. After idx 7, go to STOP.
- STOP: after DIV cycles, sample rx_s.
  - rx_s=1: push the byte and go to IDLE.
  - rx_s=0: set frame_err_o, discard the byte, go to WAIT_IDLE.
- WAIT_IDLE: stay until rx_s=1 (break/line-low handling), then go to IDLE.
- rx_en_i deasserted mid-frame: finish the current frame normally; do not start a new one.
- FIFO: first-word fall-through.
  - data_o and valid_o update the cycle after the push edge, so a byte is visible one clk after its stop-bit sample.
  - Pop on valid_o && ready_i.
  - data_o is held stable while valid_o && !ready_i.
- Push and pop in the same cycle:
  - Allowed, including when full: the push is accepted and count_o is unchanged.
  - On an empty FIFO, the pop is a no-op and the push lands.
- Push when full with no pop: the byte is dropped, overflow_o=1, FIFO contents are unchanged.
- Pointers wrap modulo FIFO_DEPTH. count_o ranges 0..FIFO_DEPTH.
- Sticky flags:
  - clr_err_i=1 clears both flags on the next edge.
  - A set event in the same cycle as clr_err_i wins, so the flag stays 1.
- Throughput: back-to-back frames (stop bit followed immediately by a start bit) are received without loss. The IDLE->START re-entry is within 1 cycle of the stop-bit sample.

Test Plan:
- Reset, then send 0x55 at 781250 baud (32 clk/bit) -> valid_o=1 one clk after stop sample, data_o=0x55, count_o=1, no flags.
- Send 0xA5, 0x00, 0xFF back-to-back, ready_i=0 -> count_o=3; then ready_i=1 for 3 cycles -> 0xA5, 0x00, 0xFF in order, valid_o=0.
- 12-clk low glitch on rx_i (< DIV/2=16) -> FSM returns to IDLE, count_o=0, frame_err_o=0.
- Frame 0x3C with stop bit low, line held low 100 clks -> frame_err_o=1, byte not pushed; next good frame 0x3C accepted. clr_err_i pulse -> frame_err_o=0.
- 17 frames 0x01..0x11 with ready_i=0, FIFO_DEPTH=16 -> count_o=16, overflow_o=1, head=0x01, 0x11 lost. Repeat with ready_i=1 in the push cycle of frame 17 -> 0x11 kept, count_o=16, overflow_o not set.
- rst_n=0 for 1 clk during DATA bit 4 -> all outputs at reset values; the remainder of the frame is ignored until the line returns high and a new start bit arrives.
